// File: rtl/z16_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the Z16CPU data bus.
// CPU stores feed a small byte FIFO; a START/DATA/STOP FSM serialises it onto o_tx.
module z16_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] CLKS_PER_BIT = 16'd8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     baudDiv_q, baudDiv_d;
  logic [15:0]     activeDiv_q, activeDiv_d;
  logic [15:0]     timer_q, timer_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitIdx_q, bitIdx_d;

  logic selData, selStat, selDiv;
  logic full, empty, pop, pushReq, push, bitDone;
  logic [3:0] countNib;

  assign selData  = (i_addr == BASE_ADDR);
  assign selStat  = (i_addr == BASE_ADDR + 16'd1);
  assign selDiv   = (i_addr == BASE_ADDR + 16'd2);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == IDLE) && !empty;
  assign pushReq  = i_we && selData;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = pushReq && (!full || pop);
  assign bitDone  = (timer_q == 16'd0);
  assign countNib = 4'(count_q);

  always_comb begin
    wrPtr_d   = wrPtr_q + PW'(push);
    rdPtr_d   = rdPtr_q + PW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    ovf_d     = ovf_q;
    baudDiv_d = baudDiv_q;
    if (i_we && selStat && i_wdata[3]) ovf_d = 1'b0;
    if (pushReq && !push) ovf_d = 1'b1;
    if (i_we && selDiv) baudDiv_d = (i_wdata < 16'd2) ? 16'd2 : i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      baudDiv_q <= CLKS_PER_BIT;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      baudDiv_q <= baudDiv_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wrPtr_q] <= i_wdata[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!empty) state_d = START;
      START: if (bitDone) state_d = DATA;
      DATA:  if (bitDone && bitIdx_q == 3'd7) state_d = STOP;
      STOP:  if (bitDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timing: the divisor is captured once per frame so BAUDDIV writes only affect later frames.
  always_comb begin
    activeDiv_d = activeDiv_q;
    shift_d     = shift_q;
    bitIdx_d    = bitIdx_q;
    timer_d     = timer_q;
    if (state_q != IDLE) timer_d = bitDone ? activeDiv_q - 16'd1 : timer_q - 16'd1;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d     = mem_q[rdPtr_q];
          bitIdx_d    = 3'd0;
          activeDiv_d = baudDiv_q;
          timer_d     = baudDiv_q - 16'd1;
        end
      end
      DATA: begin
        if (bitDone && bitIdx_q != 3'd7) begin
          bitIdx_d = bitIdx_q + 3'd1;
          shift_d  = shift_q >> 1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      activeDiv_q <= CLKS_PER_BIT;
      shift_q     <= 8'd0;
      bitIdx_q    <= 3'd0;
      timer_q     <= 16'd0;
    end else begin
      activeDiv_q <= activeDiv_d;
      shift_q     <= shift_d;
      bitIdx_q    <= bitIdx_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    o_busy = !empty || (state_q != IDLE);
    unique case (state_q)
      START:   o_tx = 1'b0;
      DATA:    o_tx = shift_q[0];
      default: o_tx = 1'b1;
    endcase
  end

  always_comb begin
    o_rdata = 16'h0000;
    if (i_re) begin
      if (selStat)     o_rdata = {8'h00, countNib, ovf_q, state_q != IDLE, empty, full};
      else if (selDiv) o_rdata = baudDiv_q;
    end
  end

endmodule

// File: tb/tb_z16_uart_tx.sv
// Directed bench for z16_uart_tx: register map, frame timing, FIFO overflow and async reset.
module tb_z16_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        tx;
  logic        busy;

  int checks = 0;
  int failures = 0;

  localparam logic [15:0] TXDATA  = 16'hFF00;
  localparam logic [15:0] STATUS  = 16'hFF01;
  localparam logic [15:0] BAUDDIV = 16'hFF02;

  z16_uart_tx dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (we),
    .i_re    (re),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_rdata (rdata),
    .o_tx    (tx),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
    we    = w;
    re    = r;
    addr  = a;
    wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(1'b1, 1'b0, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic busRead(input string tag, input logic [15:0] a, input logic [15:0] expected);
    applyStimulus(1'b0, 1'b1, a, 16'h0000);
    #1;
    checkOutput(tag, rdata, expected);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Called at the first sample after the START-entry edge; returns at the first sample after STOP.
  task automatic checkFrame(input logic [7:0] b, input int div, input string tag);
    for (int c = 0; c < 10 * div; c++) begin
      int   bn;
      logic e;
      bn = c / div;
      if (bn == 0)      e = 1'b0;
      else if (bn == 9) e = 1'b1;
      else              e = b[3'(bn - 1)];
      checkOutput(tag, {15'd0, tx}, {15'd0, e});
      tick();
    end
  endtask

  initial begin
    logic [7:0] bytes3 [6];
    int lowCount;
    int busyCount;
    bytes3 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h66};

    // Reset and idle.
    #2;
    checkOutput("rstTx", {15'd0, tx}, 16'h0001);
    checkOutput("rstBusy", {15'd0, busy}, 16'h0000);
    #20 rst_n = 1'b1;
    repeat (50) tick();
    checkOutput("idleTx", {15'd0, tx}, 16'h0001);
    checkOutput("idleBusy", {15'd0, busy}, 16'h0000);
    busRead("idleStatus", STATUS, 16'h0002);
    busRead("rstDiv", BAUDDIV, 16'h0008);

    // Single frame at the reset divisor.
    busWrite(TXDATA, 16'h1255);
    checkOutput("lat0Tx", {15'd0, tx}, 16'h0001);
    checkOutput("lat0Busy", {15'd0, busy}, 16'h0001);
    tick();
    checkFrame(8'h55, 8, "frame55");
    checkOutput("post55Tx", {15'd0, tx}, 16'h0001);
    checkOutput("post55Busy", {15'd0, busy}, 16'h0000);

    // FIFO fill, overflow, W1C and push accepted while full because of a same-cycle pop.
    busWrite(BAUDDIV, 16'h0002);
    tick();
    busWrite(TXDATA, 16'h0001);
    fork
      begin
        busWrite(TXDATA, 16'h0002);
        busWrite(TXDATA, 16'h0003);
        busWrite(TXDATA, 16'h0004);
        busWrite(TXDATA, 16'h0005);
        busWrite(TXDATA, 16'h0006);
        busRead("ovfStatus", STATUS, 16'h004D);
        busWrite(STATUS, 16'h0008);
        busRead("w1cStatus", STATUS, 16'h0045);
        repeat (15) tick();
        busWrite(TXDATA, 16'h0066);
        busRead("popPushStatus", STATUS, 16'h0045);
      end
      begin
        tick();
        for (int i = 0; i < 6; i++) begin
          checkFrame(bytes3[i], 2, "fifoFrame");
          if (i < 5) begin
            checkOutput("fifoGap", {15'd0, tx}, 16'h0001);
            tick();
          end
        end
        checkOutput("fifoDoneBusy", {15'd0, busy}, 16'h0000);
        checkOutput("fifoDoneTx", {15'd0, tx}, 16'h0001);
      end
    join

    // Divisor clamp and mid-frame divisor change.
    busWrite(BAUDDIV, 16'h0000);
    busRead("divClamp", BAUDDIV, 16'h0002);
    busWrite(TXDATA, 16'h00A3);
    fork
      begin
        repeat (3) tick();
        busWrite(BAUDDIV, 16'h0004);
        busWrite(TXDATA, 16'h003C);
        busRead("divRead4", BAUDDIV, 16'h0004);
      end
      begin
        tick();
        checkFrame(8'hA3, 2, "oldDivFrame");
        checkOutput("divGap", {15'd0, tx}, 16'h0001);
        tick();
        checkFrame(8'h3C, 4, "newDivFrame");
        checkOutput("divDoneBusy", {15'd0, busy}, 16'h0000);
      end
    join

    // Async reset during DATA bit 3 with two bytes queued.
    busWrite(TXDATA, 16'h0000);
    busWrite(TXDATA, 16'h0011);
    busWrite(TXDATA, 16'h0022);
    repeat (16) tick();
    checkOutput("bit3Tx", {15'd0, tx}, 16'h0000);
    busRead("preRstStatus", STATUS, 16'h0024);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncTx", {15'd0, tx}, 16'h0001);
    checkOutput("asyncBusy", {15'd0, busy}, 16'h0000);
    busRead("asyncStatus", STATUS, 16'h0002);
    @(negedge clk);
    rst_n = 1'b1;
    lowCount = 0;
    busyCount = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (tx !== 1'b1) lowCount++;
      if (busy !== 1'b0) busyCount++;
    end
    checkOutput("noFrameTx", 16'(lowCount), 16'h0000);
    checkOutput("noFrameBusy", 16'(busyCount), 16'h0000);
    busRead("postRstDiv", BAUDDIV, 16'h0008);

    // Read qualification and unmapped/read-only accesses.
    applyStimulus(1'b0, 1'b0, STATUS, 16'h0000);
    #1;
    checkOutput("noReStatus", rdata, 16'h0000);
    busRead("rdFF03", 16'hFF03, 16'h0000);
    busRead("rdTxData", TXDATA, 16'h0000);
    busWrite(16'hFF03, 16'hFFFF);
    busWrite(STATUS, 16'hFFF7);
    tick();
    busRead("ff03Status", STATUS, 16'h0002);
    busRead("ff03Div", BAUDDIV, 16'h0008);
    checkOutput("ff03Tx", {15'd0, tx}, 16'h0001);
    checkOutput("ff03Busy", {15'd0, busy}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
